// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, hazard/redirect controls
// and the bundle handed to the IF/ID register.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             STALL_F;
  logic             REDIRECT;
  logic [WIDTH-1:0] REDIRECT_PC;
  logic             IMEM_REQ;
  logic [WIDTH-1:0] IMEM_ADDR;
  logic             IMEM_RVALID;
  logic [WIDTH-1:0] IMEM_RDATA;
  logic [WIDTH-1:0] INST_F;
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] PCPLUS4F;
  logic             VALID_F;

  modport master (
    input  STALL_F, REDIRECT, REDIRECT_PC, IMEM_RVALID, IMEM_RDATA,
    output IMEM_REQ, IMEM_ADDR, INST_F, PCF, PCPLUS4F, VALID_F
  );

  modport slave (
    output STALL_F, REDIRECT, REDIRECT_PC, IMEM_RVALID, IMEM_RDATA,
    input  IMEM_REQ, IMEM_ADDR, INST_F, PCF, PCPLUS4F, VALID_F
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory read in flight,
// holds its bundle under stall and drops stale responses after a redirect.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          CLK,
  input logic          RST,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HAND,
    ST_DRAIN
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

  state_t           state, state_n;
  logic [WIDTH-1:0] fetch_pc;
  logic             discard;
  logic             req;
  logic             valid_q;
  logic [WIDTH-1:0] inst_q, pc_q, pcplus4_q;

  always_comb begin
    state_n = state;
    req     = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!bus.REDIRECT && !bus.STALL_F) begin
          req     = 1'b1;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.REDIRECT)
          state_n = bus.IMEM_RVALID ? ST_ISSUE : ST_DRAIN;
        else if (bus.IMEM_RVALID)
          state_n = ST_HAND;
      end
      ST_HAND: begin
        if (bus.REDIRECT) begin
          state_n = ST_ISSUE;
        end else if (!bus.STALL_F) begin
          // Bundle leaves at this edge; the next fetch overlaps with it.
          req     = 1'b1;
          state_n = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // A response landing with a redirect still retires the stale read.
        if (bus.IMEM_RVALID && discard)
          state_n = ST_ISSUE;
      end
      default: state_n = ST_ISSUE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_ISSUE;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      pcplus4_q <= '0;
    end else begin
      state <= state_n;
      if (bus.REDIRECT) begin
        fetch_pc  <= bus.REDIRECT_PC & ALIGN_MASK;
        valid_q   <= 1'b0;
        inst_q    <= '0;
        pc_q      <= '0;
        pcplus4_q <= '0;
        if (state == ST_WAIT && !bus.IMEM_RVALID)
          discard <= 1'b1;
      end else begin
        case (state)
          ST_WAIT: begin
            if (bus.IMEM_RVALID) begin
              inst_q    <= bus.IMEM_RDATA;
              pc_q      <= fetch_pc;
              pcplus4_q <= fetch_pc + FOUR;
              valid_q   <= 1'b1;
              fetch_pc  <= fetch_pc + FOUR;
            end
          end
          ST_HAND: begin
            if (!bus.STALL_F) begin
              valid_q   <= 1'b0;
              inst_q    <= '0;
              pc_q      <= '0;
              pcplus4_q <= '0;
            end
          end
          default: ;
        endcase
      end
      if (state == ST_DRAIN && bus.IMEM_RVALID)
        discard <= 1'b0;
    end
  end

  // Request is gated by reset so nothing is issued while the PC is reloading.
  assign bus.IMEM_REQ  = req & ~RST;
  assign bus.IMEM_ADDR = (req & ~RST) ? (fetch_pc & ALIGN_MASK) : '0;
  assign bus.INST_F    = inst_q;
  assign bus.PCF       = pc_q;
  assign bus.PCPLUS4F  = pcplus4_q;
  assign bus.VALID_F   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, stall hold, redirect/drain,
// PC wrap and reset-abandon behaviour.
module tb_fetch_unit;

  logic CLK;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_unit_if #(.WIDTH(32)) ifa ();
  fetch_unit_if #(.WIDTH(32)) ifb ();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .CLK (CLK),
    .RST (rst_a),
    .bus (ifa.master)
  );

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .CLK (CLK),
    .RST (rst_b),
    .bus (ifb.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic rv, input logic [31:0] rd);
    ifa.STALL_F     = stall;
    ifa.REDIRECT    = redir;
    ifa.REDIRECT_PC = rpc;
    ifa.IMEM_RVALID = rv;
    ifa.IMEM_RDATA  = rd;
    #1;
  endtask

  task automatic req_a(input string tag, input logic r, input logic [31:0] addr);
    check({tag, ".req"},  {31'd0, ifa.IMEM_REQ}, {31'd0, r});
    check({tag, ".addr"}, ifa.IMEM_ADDR, addr);
  endtask

  task automatic bundle_a(input string tag, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] p4);
    check({tag, ".valid"}, {31'd0, ifa.VALID_F}, {31'd0, v});
    check({tag, ".inst"},  ifa.INST_F, inst);
    check({tag, ".pcf"},   ifa.PCF, pc);
    check({tag, ".pc4"},   ifa.PCPLUS4F, p4);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifb.STALL_F = 1'b0; ifb.REDIRECT = 1'b0; ifb.REDIRECT_PC = '0;
    ifb.IMEM_RVALID = 1'b0; ifb.IMEM_RDATA = '0;
    drive_a(0, 0, 0, 0, 0);
    tick();
    tick();
    bundle_a("rst", 0, 0, 0, 0);
    req_a("rst", 0, 0);

    // Sequential fetch with 1-cycle memory
    rst_a = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    req_a("seq0", 1, 32'h0);
    tick();
    drive_a(0, 0, 0, 1, 32'hA0);
    req_a("wait0", 0, 0);
    bundle_a("wait0", 0, 0, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("hand0", 1, 32'hA0, 32'h0, 32'h4);
    req_a("seq4", 1, 32'h4);
    tick();
    drive_a(0, 0, 0, 1, 32'hA1);
    bundle_a("wait1", 0, 0, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("hand1", 1, 32'hA1, 32'h4, 32'h8);
    req_a("seq8", 1, 32'h8);
    tick();
    drive_a(0, 0, 0, 1, 32'hA2);
    tick();

    // Stall holds the bundle at PCF=8 for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 0, 0, 0, 0);
      bundle_a("stall", 1, 32'hA2, 32'h8, 32'hC);
      req_a("stall", 0, 0);
      tick();
    end
    drive_a(0, 0, 0, 0, 0);
    bundle_a("unstall", 1, 32'hA2, 32'h8, 32'hC);
    req_a("unstall", 1, 32'hC);
    tick();
    drive_a(0, 0, 0, 1, 32'hA3);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("handC", 1, 32'hA3, 32'hC, 32'h10);
    req_a("seq10", 1, 32'h10);
    tick();

    // 3-cycle latency, redirect while waiting -> drain
    drive_a(0, 1, 32'h103, 0, 0);
    req_a("redir_wait", 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("drain1", 0, 0, 0, 0);
    req_a("drain1", 0, 0);
    tick();
    drive_a(0, 0, 0, 1, 32'hDEAD);
    req_a("drain2", 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("dropped", 0, 0, 0, 0);
    req_a("tgt100", 1, 32'h100);
    tick();
    drive_a(0, 0, 0, 1, 32'hB0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("hand100", 1, 32'hB0, 32'h100, 32'h104);
    req_a("seq104", 1, 32'h104);
    tick();

    // Redirect coinciding with response in WAIT
    drive_a(0, 1, 32'h200, 1, 32'hBAD);
    req_a("redir_rv", 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("redir_rv", 0, 0, 0, 0);
    req_a("tgt200", 1, 32'h200);
    tick();
    drive_a(0, 0, 0, 1, 32'hC0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("hand200", 1, 32'hC0, 32'h200, 32'h204);

    // Redirect beats stall in HAND
    drive_a(1, 1, 32'h300, 0, 0);
    req_a("redir_hand", 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("redir_hand", 0, 0, 0, 0);
    req_a("tgt300", 1, 32'h300);
    tick();

    // Reset while WAIT, then stray response
    rst_a = 1'b1;
    #1;
    bundle_a("rst_wait", 0, 0, 0, 0);
    req_a("rst_wait", 0, 0);
    tick();
    rst_a = 1'b0;
    drive_a(0, 0, 0, 1, 32'hEE);
    req_a("post_rst", 1, 32'h0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("stray", 0, 0, 0, 0);
    drive_a(0, 0, 0, 1, 32'hD0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    bundle_a("post_rst", 1, 32'hD0, 32'h0, 32'h4);

    // PC wrap from RESET_PC=0xFFFFFFFC
    rst_b = 1'b0;
    #1;
    check("wrap.req0", {31'd0, ifb.IMEM_REQ}, 32'd1);
    check("wrap.addr0", ifb.IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    ifb.IMEM_RVALID = 1'b1;
    ifb.IMEM_RDATA  = 32'hE0;
    tick();
    ifb.IMEM_RVALID = 1'b0;
    #1;
    check("wrap.valid", {31'd0, ifb.VALID_F}, 32'd1);
    check("wrap.inst", ifb.INST_F, 32'hE0);
    check("wrap.pcf", ifb.PCF, 32'hFFFF_FFFC);
    check("wrap.pc4", ifb.PCPLUS4F, 32'h0);
    check("wrap.addr1", ifb.IMEM_ADDR, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
